lcd_pattern_gen: RTL

Raster test-pattern source that sits directly upstream of lcdPixelWriter and feeds it pixels.
- Answers the writer's `data_req` with one 24-bit RGB pixel per request, in raster order (left→right, top→bottom) over the active area.
- Selectable patterns: solid colour, colour bars, checkerboard, gradient.
- Used for panel bring-up and as the default source when no frame memory is present.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_raster_counter.sv | 49 ++++
 rtl/lcd_pattern_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD raster test-pattern source.
package lcd_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    BARS     = 2'd1,
    CHECKER  = 2'd2,
    GRADIENT = 2'd3
  } pattern_mode_e;

  localparam int H_ACTIVE_DEF   = 480;
  localparam int V_ACTIVE_DEF   = 272;
  localparam int CHECK_LOG2_DEF = 4;

  // Classic colour-bar order, left to right.
  localparam rgb_t BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/lcd_raster_counter.sv
// Raster x/y position counter: advances once per accepted pixel, wraps at the
// active-area edges, and reloads to the origin on a resync.
module lcd_raster_counter #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        advance_i,
  input  logic                        load_i,
  output logic [$clog2(H_ACTIVE)-1:0] x_o,
  output logic [$clog2(V_ACTIVE)-1:0] y_o,
  output logic                        at_origin_o,
  output logic                        at_last_o
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (load_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign at_origin_o = (x_q == '0) && (y_q == '0);
  assign at_last_o   = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/lcd_pattern_gen.sv
// Raster test-pattern source answering lcdPixelWriter pixel requests.
// Define PATTERN_SCROLL_EN to add a horizontal scroll that advances each frame.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int CHECK_LOG2 = CHECK_LOG2_DEF
) (
  input  logic        clk_12mhz,
  input  logic        rst,
  input  logic        data_req,
  input  logic        sof,
  input  logic [1:0]  mode,
  input  logic [23:0] color,
  output logic [23:0] rgb,
  output logic        data_valid,
  output logic        frame_done
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);

  logic [XW-1:0] x;
  logic [XW-1:0] xe;
  logic [YW-1:0] y;
  logic          at_origin;
  logic          at_last;
  logic          accept;

  pattern_mode_e mode_q;
  pattern_mode_e mode_eff;
  rgb_t          color_q;
  rgb_t          color_eff;
  rgb_t          rgb_q;
  rgb_t          pixel_d;
  logic          data_valid_q;
  logic          frame_done_q;
  logic [2:0]    bar_idx;
  logic          checker_odd;

  // sof wins over a simultaneous request; that request is dropped.
  assign accept = data_req & ~sof;

  lcd_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk         (clk_12mhz),
    .rst_n       (rst),
    .advance_i   (accept),
    .load_i      (sof),
    .x_o         (x),
    .y_o         (y),
    .at_origin_o (at_origin),
    .at_last_o   (at_last)
  );

`ifdef PATTERN_SCROLL_EN
  localparam logic [XW:0] H_LIM = (XW+1)'(H_ACTIVE);

  logic [XW-1:0] scroll_q;
  logic [XW:0]   scroll_sum;
  logic [XW:0]   x_sum;

  assign scroll_sum = {1'b0, scroll_q} + (XW+1)'(2);
  assign x_sum      = {1'b0, x} + {1'b0, scroll_q};
  assign xe         = (x_sum >= H_LIM) ? XW'(x_sum - H_LIM) : x_sum[XW-1:0];

  // Scroll steps as the last pixel of a frame is accepted, so the next
  // frame's origin pixel already sees the new offset.
  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      scroll_q <= '0;
    end else if (sof) begin
      scroll_q <= '0;
    end else if (accept && at_last) begin
      scroll_q <= (scroll_sum >= H_LIM) ? XW'(scroll_sum - H_LIM) : scroll_sum[XW-1:0];
    end
  end
`else
  assign xe = x;
`endif

  // The origin pixel uses the live mode/colour, which are latched for the
  // rest of the frame at the same time.
  assign mode_eff    = at_origin ? pattern_mode_e'(mode) : mode_q;
  assign color_eff   = at_origin ? color : color_q;
  assign bar_idx     = 3'(xe / BAR_W);
  assign checker_odd = xe[CHECK_LOG2] ^ y[CHECK_LOG2];

  // NOTE: pixel_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pixel_d = color_eff;
    unique case (mode_eff)
      SOLID:    pixel_d = color_eff;
      BARS:     pixel_d = BAR_COLORS[bar_idx];
      CHECKER:  pixel_d = checker_odd ? 24'h000000 : color_eff;
      GRADIENT: pixel_d = {8'(xe >> 1), 8'(y >> 1), 8'h80};
    endcase
  end

  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      rgb_q        <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      mode_q       <= SOLID;
      color_q      <= '0;
    end else begin
      data_valid_q <= accept;
      frame_done_q <= accept & at_last;
      if (accept) begin
        rgb_q <= pixel_d;
        if (at_origin) begin
          mode_q  <= mode_eff;
          color_q <= color;
        end
      end
    end
  end

  assign rgb        = rgb_q;
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;

endmodule
